// File: rtl/bus_slave_resp_mux_pkg.sv
// Shared definitions for the slave response multiplexer: active-low level names,
// default word width and the FSM state encoding.
package bus_slave_resp_mux_pkg;

  localparam logic ENABLE_N    = 1'b0;
  localparam logic DISABLE_N   = 1'b1;
  localparam int   WORD_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/bus_slave_sel_enc.sv
// Lowest-index priority encoder: picks the lowest set bit of req and flags
// whether any bit was set.
module bus_slave_sel_enc
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = ($clog2(N))'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_slave_resp_mux.sv
// Routes one selected slave's read response back to the master, with
// decode-error and timeout bus errors; all master-side outputs are registered.
module bus_slave_resp_mux
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int SLAVE_NUM = 8,
  parameter int DATA_W    = WORD_DATA_W,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mAs_,
  input  logic [SLAVE_NUM-1:0]        sCS_,
  input  logic [SLAVE_NUM*DATA_W-1:0] sRdData,
  input  logic [SLAVE_NUM-1:0]        sRdy_,
  output logic [DATA_W-1:0]           mRdData,
  output logic                        mRdy_,
  output logic                        busErr,
  output state_e                      dbg_state
);

  localparam int SEL_W = $clog2(SLAVE_NUM);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Handshake: a master access starts on any cycle mAs_ is sampled low in IDLE;
  // the response is exactly one cycle of mRdy_ low, with busErr and mRdData valid
  // only in that cycle. Slave ready is sampled only for the latched selection.
  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mrdy_q, mrdy_d;
  logic                buserr_q, buserr_d;
  logic [DATA_W-1:0]   mrddata_q, mrddata_d;

  logic [SEL_W-1:0]    enc_idx;
  logic                enc_valid;
  logic [DATA_W-1:0]   sel_data;

  bus_slave_sel_enc #(
    .N (SLAVE_NUM)
  ) u_sel_enc (
    .req   (~sCS_),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign sel_data = sRdData[sel_q*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    mrdy_d    = DISABLE_N;
    buserr_d  = 1'b0;
    mrddata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (mAs_ == ENABLE_N) begin
          if (enc_valid) begin
            sel_d   = enc_idx;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            mrdy_d   = ENABLE_N;
            buserr_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Ready is tested before the timeout so a late ready still wins.
        if (sRdy_[sel_q] == ENABLE_N) begin
          mrdy_d    = ENABLE_N;
          mrddata_d = sel_data;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mrdy_d   = ENABLE_N;
          buserr_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      mrdy_q    <= DISABLE_N;
      buserr_q  <= 1'b0;
      mrddata_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      mrdy_q    <= mrdy_d;
      buserr_q  <= buserr_d;
      mrddata_q <= mrddata_d;
    end
  end

  assign mRdData   = mrddata_q;
  assign mRdy_     = mrdy_q;
  assign busErr    = buserr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// Directed bench for bus_slave_resp_mux (8 slaves, 32-bit data, TIMEOUT=4):
// a table of single accesses plus hand-written back-to-back and reset sequences.
module tb_bus_slave_resp_mux;
  import bus_slave_resp_mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int TO = 4;

  logic           clk;
  logic           reset;
  logic           mAs_;
  logic [N-1:0]   sCS_;
  logic [N*W-1:0] sRdData;
  logic [N-1:0]   sRdy_;
  logic [W-1:0]   mRdData;
  logic           mRdy_;
  logic           busErr;
  state_e         dbg_state;

  int checks = 0;
  int errors = 0;

  bus_slave_resp_mux #(
    .SLAVE_NUM (N),
    .DATA_W    (W),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mAs_      (mAs_),
    .sCS_      (sCS_),
    .sRdData   (sRdData),
    .sRdy_     (sRdy_),
    .mRdData   (mRdData),
    .mRdy_     (mRdy_),
    .busErr    (busErr),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rdy_at: WAIT cycle (0 = first) in which the selected slave goes ready; 99 = never.
  // exp_lat: clock edges from the one sampling mAs_ (counted as 1) to mRdy_ low.
  typedef struct {
    logic [N-1:0] cs_n;
    logic [N-1:0] noise;
    int           rdy_at;
    int           sel;
    logic [W-1:0] exp_data;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy_idle"}, W'(mRdy_), W'(1'b1));
    check({tag, "_err_idle"}, W'(busErr), W'(1'b0));
    check({tag, "_data_idle"}, mRdData, '0);
  endtask

  // driver: one table-driven access, inputs driven #1 after each active edge
  task automatic run_vec(input int k, input vec_t v);
    int  lat;
    bit  seen;
    string tag;
    logic [N-1:0] sel_bit;
    tag     = $sformatf("vec%0d", k);
    sel_bit = N'(1) << v.sel;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    mAs_  = 1'b0;
    sCS_  = v.cs_n;
    sRdy_ = '1;
    while (!seen && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      mAs_ = 1'b1;
      sCS_ = N'($urandom_range(0, 255));
      if (mRdy_ == 1'b0) begin
        seen = 1'b1;
      end else begin
        sRdy_ = ~(v.noise | (((lat - 1) >= v.rdy_at) ? sel_bit : '0));
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_response required=mRdy_low_within_%0d", tag, lat);
    end else begin
      check({tag, "_lat"}, W'(lat), W'(v.exp_lat));
      check({tag, "_data"}, mRdData, v.exp_data);
      check({tag, "_err"}, W'(busErr), W'(v.exp_err));
      check({tag, "_state"}, W'(dbg_state), W'(ST_IDLE));
    end
    sCS_  = '1;
    sRdy_ = '1;
    @(posedge clk);
    #1;
    check_idle(tag);
  endtask

  initial begin
    int lows;
    for (int i = 0; i < N; i++) sRdData[i*W +: W] = 32'h1111_1111 * (i + 1);
    sRdData[2*W +: W] = 32'hDEAD_BEEF;

    vecs[0] = '{8'hFB, 8'h00, 2,  2, 32'hDEAD_BEEF, 1'b0, 4}; // ready two WAIT cycles in
    vecs[1] = '{8'hF5, 8'h08, 1,  1, 32'h2222_2222, 1'b0, 3}; // slave 1 wins, slave 3 noise
    vecs[2] = '{8'hF5, 8'h08, 99, 1, 32'h0000_0000, 1'b1, 5}; // only non-selected ready -> timeout
    vecs[3] = '{8'hFF, 8'h00, 99, 0, 32'h0000_0000, 1'b1, 1}; // decode error
    vecs[4] = '{8'h7F, 8'h00, 0,  7, 32'h8888_8888, 1'b0, 2}; // highest slave, immediate ready
    vecs[5] = '{8'h00, 8'h00, 3,  0, 32'h1111_1111, 1'b0, 5}; // ready on last count beats timeout
    vecs[6] = '{8'hFE, 8'hFE, 99, 0, 32'h0000_0000, 1'b1, 5}; // all others ready, still timeout
    vecs[7] = '{8'hEF, 8'h00, 1,  4, 32'h5555_5555, 1'b0, 3};

    reset = 1'b1;
    mAs_  = 1'b1;
    sCS_  = '1;
    sRdy_ = '1;
    #12;
    check_idle("reset");
    check("reset_state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // back-to-back: new mAs_ accepted in the response cycle
    @(negedge clk);
    mAs_ = 1'b0;
    sCS_ = 8'hFE;
    @(posedge clk); #1;
    mAs_ = 1'b1;
    sCS_ = '1;
    repeat (3) begin @(posedge clk); #1; end
    sRdy_ = 8'hFE;
    @(posedge clk); #1;
    check("b2b_first_rdy", W'(mRdy_), W'(1'b0));
    check("b2b_first_err", W'(busErr), W'(1'b0));
    check("b2b_first_data", mRdData, 32'h1111_1111);
    mAs_  = 1'b0;
    sCS_  = 8'hFB;
    sRdy_ = '1;
    @(posedge clk); #1;
    mAs_ = 1'b1;
    sCS_ = '1;
    check("b2b_second_wait_rdy", W'(mRdy_), W'(1'b1));
    check("b2b_second_state", W'(dbg_state), W'(ST_WAIT));
    sRdy_ = 8'hFB;
    @(posedge clk); #1;
    check("b2b_second_rdy", W'(mRdy_), W'(1'b0));
    check("b2b_second_data", mRdData, 32'hDEAD_BEEF);
    check("b2b_second_err", W'(busErr), W'(1'b0));
    sRdy_ = '1;
    @(posedge clk); #1;
    check_idle("b2b");

    // reset mid-WAIT abandons the access
    mAs_ = 1'b0;
    sCS_ = 8'hFB;
    @(posedge clk); #1;
    mAs_ = 1'b1;
    sCS_ = '1;
    @(posedge clk); #1;
    check("rst_wait_state", W'(dbg_state), W'(ST_WAIT));
    #2 reset = 1'b1;
    #1;
    check("rst_async_state", W'(dbg_state), W'(ST_IDLE));
    #2 reset = 1'b0;
    sRdy_ = 8'hFB;
    lows = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mRdy_ == 1'b0 || busErr != 1'b0 || mRdData != '0) lows++;
    end
    check("rst_no_response", W'(lows), '0);
    check("rst_after_state", W'(dbg_state), W'(ST_IDLE));
    sRdy_ = '1;

    // reset during a response cycle clears the registered outputs at once
    @(negedge clk);
    mAs_ = 1'b0;
    sCS_ = 8'hFF;
    @(posedge clk); #1;
    mAs_ = 1'b1;
    check("rst_resp_rdy_before", W'(mRdy_), W'(1'b0));
    check("rst_resp_err_before", W'(busErr), W'(1'b1));
    reset = 1'b1;
    #1;
    check_idle("rst_resp");
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_slave_resp_mux.md
BUS_SLAVE_RESP_MUX -- requirements
Module: bus_slave_resp_mux

Interface
REQ-001 SHALL have parameter SLAVE_NUM, default 8, number of slave channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, read-data width per slave.
REQ-003 SHALL have parameter TIMEOUT, default 255, wait cycles before bus error (1..65535).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port mAs_, input, 1, master address strobe, active low, one-cycle pulse per access.
REQ-007 SHALL have port sCS_, input, SLAVE_NUM, slave chip selects, active low, bit i = slave i.
REQ-008 SHALL have port sRdData, input, SLAVE_NUM*DATA_W, packed slave read data, slave i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port sRdy_, input, SLAVE_NUM, slave ready, active low.
REQ-010 SHALL have port mRdData, output, DATA_W, registered read data to master.
REQ-011 SHALL have port mRdy_, output, 1, registered ready to master, active low, one-cycle pulse.
REQ-012 SHALL have port busErr, output, 1, active high, asserted only together with mRdy_ low.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-014 IDLE, mAs_ low, at least one sCS_ bit low: SHALL latch lowest-index low sCS_ bit as sel, clear timeout counter, go WAIT.
REQ-015 IDLE, mAs_ low, all sCS_ high: SHALL, next cycle, drive mRdy_ low, busErr high, mRdData 0 (decode error); stay IDLE.
REQ-016 WAIT: SHALL ignore sCS_ and mAs_; selection fixed until response.
REQ-017 WAIT, sRdy_[sel] low: SHALL register sRdData slice sel into mRdData, drive mRdy_ low, busErr low next cycle; go IDLE.
REQ-018 WAIT, sRdy_[sel] high: SHALL increment counter; when counter reaches TIMEOUT-1, next cycle drive mRdy_ low, busErr high, mRdData 0; go IDLE.
REQ-019 Ready and timeout in same cycle: ready SHALL win (no error).
REQ-020 Latency: SHALL be exactly one cycle from sampled slave ready to mRdy_ low.
REQ-021 Outside response cycles SHALL hold mRdy_ high, busErr low, mRdData 0.
REQ-022 Back-to-back: SHALL accept a new mAs_ in the same cycle mRdy_ is low.
REQ-023 Counter width SHALL be $clog2(TIMEOUT+1); counter SHALL never wrap.
REQ-024 Ready bits of non-selected slaves SHALL have no effect.

Reset
REQ-025 reset high SHALL asynchronously force state IDLE, sel 0, counter 0, mRdy_ high, busErr low, mRdData 0.
REQ-026 reset during WAIT SHALL abandon the access with no response pulse after release.

Structure
REQ-027 ENABLE/DISABLE (active-low levels) and WORD_DATA_W default SHALL come from the shared bus/stddef include files; FSM state encodings SHALL be added to the shared bus include.
REQ-028 Lowest-index selection SHALL be a sub-module bus_slave_sel_enc (SLAVE_NUM-bit input, index and valid outputs).

Verification
REQ-029 mAs_ low, sCS_=8'hFB, sRdData slice 2=32'hDEADBEEF, sRdy_[2] low 3 cycles later -> mRdy_ low one cycle later, mRdData=32'hDEADBEEF, busErr 0.
REQ-030 sCS_=8'hF5 (slaves 1,3 low) -> slave 1 selected; sRdy_[3] low alone gives no response; sRdy_[1] low then responds.
REQ-031 TIMEOUT=4, slave never ready -> mRdy_ low, busErr 1, mRdData 0 exactly 5 cycles after mAs_ sample.
REQ-032 mAs_ low, sCS_=8'hFF -> next cycle mRdy_ low, busErr 1; state remains IDLE.
REQ-033 Ready on cycle TIMEOUT-1 -> normal response, busErr 0; second mAs_ in response cycle accepted.
REQ-034 reset pulsed mid-WAIT, later sRdy_ low -> no mRdy_ pulse; all outputs at reset values.
